note_chart_feeder: RTL and testbench

Drives the two scroll lanes of the Guitar Villains note display. In play mode it fetches per-bar 32-bit note patterns for lane 1 and lane 2 from a chart ROM and advances a 5-bit scroll index at a fixed step rate. It presents `next_note1/2` and `next_idx1/2` to the LED display windowing logic, which consumes them every cycle. It also emits a per-step strobe for scoring logic and a song-done flag.

---
 rtl/gv_pkg.sv | 16 +
 rtl/note_chart_rom.sv | 22 ++
 rtl/note_chart_feeder.sv | 138 +++++++++++++
 tb/tb_note_chart_feeder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gv_pkg.sv
// Shared types and constants for the Guitar Villains note display path.
package gv_pkg;

  localparam logic [2:0]  MODE_PLAY = 3'd2;
  localparam int unsigned NOTE_W    = 32;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned BAR_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/note_chart_rom.sv
// Fixed song chart: per-bar 32-bit note patterns for both scroll lanes.
module note_chart_rom
  import gv_pkg::*;
(
  input  logic [BAR_W-1:0]  bar_addr,
  output logic [NOTE_W-1:0] lane1,
  output logic [NOTE_W-1:0] lane2
);

  always_comb begin
    lane1 = '0;
    lane2 = '0;
    case (bar_addr)
      4'd0: begin lane1 = 32'hF0F0_F0F0; lane2 = 32'h0F0F_0F0F; end
      4'd1: begin lane1 = 32'hAAAA_AAAA; lane2 = 32'h5555_5555; end
      4'd2: begin lane1 = 32'h8000_0001; lane2 = 32'h0001_8000; end
      4'd3: begin lane1 = 32'hFFFF_0000; lane2 = 32'h0000_FFFF; end
      default: ;
    endcase
  end

endmodule

// File: rtl/note_chart_feeder.sv
// Feeds bar patterns and a stepped scroll index to both LED lanes during play mode.
module note_chart_feeder
  import gv_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = 2_500_000,
  parameter int unsigned NUM_BARS       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic              start,
  output logic [NOTE_W-1:0] next_note1,
  output logic [NOTE_W-1:0] next_note2,
  output logic [IDX_W-1:0]  next_idx1,
  output logic [IDX_W-1:0]  next_idx2,
  output logic              step,
  output logic [BAR_W-1:0]  bar,
  output logic              song_done
);

  localparam int unsigned      TICK_W    = $clog2(TICKS_PER_STEP);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICKS_PER_STEP - 2);
  localparam logic [BAR_W-1:0]  BAR_LAST  = BAR_W'(NUM_BARS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = '1;

  feeder_state_t     r_state, w_state_nxt;
  logic [TICK_W-1:0] r_tick, w_tick_nxt;
  logic [IDX_W-1:0]  r_idx, r_idx2, w_idx_nxt;
  logic [BAR_W-1:0]  r_bar, w_bar_nxt;
  logic [NOTE_W-1:0] r_note1, r_note2, w_note1_nxt, w_note2_nxt;
  logic              r_step, w_step_nxt;
  logic              r_done, w_done_nxt;
  logic [BAR_W-1:0]  w_rom_addr;
  logic [NOTE_W-1:0] w_rom_l1, w_rom_l2;

  // In PLAY the ROM looks one bar ahead so a bar change loads on the same edge as the idx wrap.
  assign w_rom_addr = (r_state == PLAY) ? BAR_W'(r_bar + 1'b1) : r_bar;

  note_chart_rom u_rom (
    .bar_addr (w_rom_addr),
    .lane1    (w_rom_l1),
    .lane2    (w_rom_l2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_idx2  <= '0;
      r_bar   <= '0;
      r_note1 <= '0;
      r_note2 <= '0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_idx   <= w_idx_nxt;
      r_idx2  <= w_idx_nxt;
      r_bar   <= w_bar_nxt;
      r_note1 <= w_note1_nxt;
      r_note2 <= w_note2_nxt;
      r_step  <= w_step_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_idx_nxt   = r_idx;
    w_bar_nxt   = r_bar;
    w_note1_nxt = r_note1;
    w_note2_nxt = r_note2;
    w_step_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start && (mode == MODE_PLAY)) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_note1_nxt = w_rom_l1;
        w_note2_nxt = w_rom_l2;
        w_tick_nxt  = '0;
        w_idx_nxt   = '0;
        w_state_nxt = PLAY;
      end
      PLAY: begin
        // Step is registered, so it is raised one cycle ahead to line up with the terminal tick.
        w_step_nxt = (r_tick == TICK_PRE);
        if (r_tick == TICK_LAST) begin
          w_tick_nxt = '0;
          if (r_idx != IDX_LAST) begin
            w_idx_nxt = IDX_W'(r_idx + 1'b1);
          end else if (r_bar != BAR_LAST) begin
            w_bar_nxt   = BAR_W'(r_bar + 1'b1);
            w_idx_nxt   = '0;
            w_note1_nxt = w_rom_l1;
            w_note2_nxt = w_rom_l2;
          end else begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_tick_nxt = TICK_W'(r_tick + 1'b1);
        end
      end
      DONE: begin
        w_done_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Leaving play mode overrides everything, including a pending step.
    if ((r_state != IDLE) && (mode != MODE_PLAY)) begin
      w_state_nxt = IDLE;
      w_tick_nxt  = '0;
      w_idx_nxt   = '0;
      w_bar_nxt   = '0;
      w_note1_nxt = '0;
      w_note2_nxt = '0;
      w_step_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  assign next_note1 = r_note1;
  assign next_note2 = r_note2;
  assign next_idx1  = r_idx;
  assign next_idx2  = r_idx2;
  assign step       = r_step;
  assign bar        = r_bar;
  assign song_done  = r_done;

endmodule

// File: tb/tb_note_chart_feeder.sv
// Self-checking bench for note_chart_feeder against a cycle-count song model.
module tb_note_chart_feeder;

  localparam int T    = 4;
  localparam int NB   = 2;
  localparam int SONG = 32 * NB * T;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic        start;
  logic [31:0] next_note1, next_note2;
  logic [4:0]  next_idx1, next_idx2;
  logic        step;
  logic [3:0]  bar;
  logic        song_done;

  int errors = 0;
  int checks = 0;
  int cur    = 0;

  logic [31:0] rom1 [16];
  logic [31:0] rom2 [16];

  int m_phase = 0;   // 0 idle, 1 load, 2 play, 3 done
  int m_p     = 0;   // cycles elapsed in PLAY

  note_chart_feeder #(.TICKS_PER_STEP(T), .NUM_BARS(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .start      (start),
    .next_note1 (next_note1),
    .next_note2 (next_note2),
    .next_idx1  (next_idx1),
    .next_idx2  (next_idx2),
    .step       (step),
    .bar        (bar),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Song model: position in the song is a single play-cycle count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_p     <= 0;
    end else if (m_phase != 0 && mode != 3'd2) begin
      m_phase <= 0;
      m_p     <= 0;
    end else begin
      case (m_phase)
        0: if (start && mode == 3'd2) m_phase <= 1;
        1: begin m_phase <= 2; m_p <= 0; end
        2: if (m_p == SONG - 1) m_phase <= 3; else m_p <= m_p + 1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    int eb, ei;
    logic es, ed;
    logic [31:0] e1, e2;
    eb = 0; ei = 0; es = 1'b0; ed = 1'b0; e1 = '0; e2 = '0;
    if (m_phase == 2) begin
      eb = m_p / (32 * T);
      ei = (m_p / T) % 32;
      es = (m_p % T) == T - 1;
      e1 = rom1[eb]; e2 = rom2[eb];
    end else if (m_phase == 3) begin
      eb = NB - 1; ei = 31; ed = 1'b1;
      e1 = rom1[eb]; e2 = rom2[eb];
    end
    chk("model_note1", 64'(next_note1), 64'(e1));
    chk("model_note2", 64'(next_note2), 64'(e2));
    chk("model_idx1",  64'(next_idx1),  64'(ei));
    chk("model_idx2",  64'(next_idx2),  64'(ei));
    chk("model_bar",   64'(bar),        64'(eb));
    chk("model_step",  64'(step),       64'(es));
    chk("model_done",  64'(song_done),  64'(ed));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int k);
    while (cur < k) begin
      cyc();
      cur++;
    end
  endtask

  task automatic begin_song();
    mode  = 3'd2;
    start = 1'b1;
    cur   = 0;
    cyc();
    cur   = 1;
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin rom1[i] = '0; rom2[i] = '0; end
    rom1[0] = 32'hF0F0_F0F0; rom2[0] = 32'h0F0F_0F0F;
    rom1[1] = 32'hAAAA_AAAA; rom2[1] = 32'h5555_5555;
    rom1[2] = 32'h8000_0001; rom2[2] = 32'h0001_8000;
    rom1[3] = 32'hFFFF_0000; rom2[3] = 32'h0000_FFFF;

    rst = 1'b1; mode = 3'd0; start = 1'b0;
    cyc(); cyc();
    chk("rst_note1", 64'(next_note1), 64'd0);
    chk("rst_idx",   64'(next_idx1),  64'd0);
    chk("rst_done",  64'(song_done),  64'd0);
    rst = 1'b0;
    cyc(); cyc();

    // Opening timing and first step
    begin_song();
    chk("load_note1", 64'(next_note1), 64'd0);
    go(2);
    chk("n2_note1", 64'(next_note1), 64'hF0F0_F0F0);
    chk("n2_note2", 64'(next_note2), 64'h0F0F_0F0F);
    chk("n2_idx",   64'(next_idx1),  64'd0);
    chk("n2_step",  64'(step),       64'd0);
    go(4);
    chk("n4_step", 64'(step), 64'd0);
    go(5);
    chk("n5_step", 64'(step),      64'd1);
    chk("n5_idx",  64'(next_idx1), 64'd0);
    go(6);
    chk("n6_idx",  64'(next_idx1), 64'd1);
    chk("n6_step", 64'(step),      64'd0);
    go(7);
    start = 1'b1;
    go(8);
    start = 1'b0;
    chk("restart_ignored_idx", 64'(next_idx1), 64'd1);

    // Bar boundary and song end
    go(129);
    chk("n129_idx",  64'(next_idx1), 64'd31);
    chk("n129_step", 64'(step),      64'd1);
    chk("n129_bar",  64'(bar),       64'd0);
    go(130);
    chk("n130_bar",   64'(bar),        64'd1);
    chk("n130_idx",   64'(next_idx1),  64'd0);
    chk("n130_note1", 64'(next_note1), 64'hAAAA_AAAA);
    chk("n130_note2", 64'(next_note2), 64'h5555_5555);
    go(257);
    chk("n257_done", 64'(song_done), 64'd0);
    go(258);
    chk("n258_done", 64'(song_done), 64'd1);
    chk("n258_idx",  64'(next_idx1), 64'd31);
    chk("n258_bar",  64'(bar),       64'd1);
    go(265);
    chk("done_step", 64'(step),      64'd0);
    chk("done_idx",  64'(next_idx1), 64'd31);

    // Mode exit on the edge that would raise a step
    mode = 3'd0;
    cyc();
    begin_song();
    go(24);
    chk("pre_exit_idx", 64'(next_idx1), 64'd5);
    mode = 3'd1;
    go(25);
    chk("exit_step",  64'(step),       64'd0);
    chk("exit_note1", 64'(next_note1), 64'd0);
    chk("exit_idx",   64'(next_idx1),  64'd0);

    // Start outside play mode is ignored
    mode = 3'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    chk("mode0_start_note1", 64'(next_note1), 64'd0);

    // Asynchronous reset mid bar 1
    begin_song();
    go(140);
    chk("pre_rst_bar", 64'(bar),       64'd1);
    chk("pre_rst_idx", 64'(next_idx1), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("async_note1", 64'(next_note1), 64'd0);
    chk("async_bar",   64'(bar),        64'd0);
    chk("async_idx",   64'(next_idx1),  64'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    begin_song();
    go(2);
    chk("replay_note1", 64'(next_note1), 64'hF0F0_F0F0);
    chk("replay_bar",   64'(bar),        64'd0);

    // Randomized mode glitches and start pulses
    for (int i = 0; i < 3000; i++) begin
      cyc();
      mode  = ($urandom_range(0, 99) < 2) ? 3'($urandom_range(0, 7)) : 3'd2;
      start = ($urandom_range(0, 19) == 0);
    end
    start = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
